// File: rtl/ifmap_stream_if.sv
// Control, SRAM-read and ifmap-stream signals of the ifmap stream controller.
// The slave modport is the controller's view; the master modport is the feeder/SRAM side.
interface ifmap_stream_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_vec;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] ifmap_out;
  logic              ifmap_valid;
  logic              busy;
  logic              done;

  modport slave (
    input  start, abort, base_addr, num_vec, mem_rd_data,
    output mem_rd_en, mem_addr, ifmap_out, ifmap_valid, busy, done
  );

  modport master (
    output start, abort, base_addr, num_vec, mem_rd_data,
    input  mem_rd_en, mem_addr, ifmap_out, ifmap_valid, busy, done
  );
endinterface

// File: rtl/ifmap_stream_ctrl.sv
// Streams num_vec ifmap vectors out of a synchronous SRAM into the row-skew stage,
// then holds zeros until the most-delayed skew row has flushed, and pulses done.
module ifmap_stream_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ROWS        = 4,
  parameter int unsigned MAC_LATENCY = 9,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic           clk,
  input  logic           rst,
  ifmap_stream_if.slave  bus
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned DRAIN_LEN = MAC_LATENCY * (ROWS - 1);
  // DRAIN also covers the reads still in flight plus the output register stage.
  localparam int unsigned DRAIN_CYC = DRAIN_LEN + RD_LATENCY;
  localparam int unsigned DCNT_W    = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      num_q, num_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DCNT_W-1:0]     dcnt_q, dcnt_d;
  logic [RD_LATENCY-1:0] inflight_q, inflight_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      num_q      <= '0;
      cnt_q      <= '0;
      dcnt_q     <= '0;
      inflight_q <= '0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      dcnt_q     <= dcnt_d;
      inflight_q <= inflight_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state, read sequencing and the returned-data path
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    dcnt_d     = dcnt_q;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    inflight_d = RD_LATENCY'({inflight_q, rd_en_q});
    valid_d    = inflight_q[RD_LATENCY-1];
    out_d      = valid_d ? bus.mem_rd_data : '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          num_d  = bus.num_vec;
          busy_d = 1'b1;
          if (bus.num_vec == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
            rd_en_d = 1'b1;
            addr_d  = bus.base_addr;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      FETCH: begin
        // cnt_q counts reads already issued, including the one on the bus now
        if (cnt_q == num_q) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          rd_en_d = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (dcnt_q == DCNT_W'(DRAIN_CYC)) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Abort drops everything, including data from reads already issued
    if (bus.abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      rd_en_d    = 1'b0;
      inflight_d = '0;
      valid_d    = 1'b0;
      out_d      = '0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_addr    = addr_q;
  assign bus.ifmap_out   = out_q;
  assign bus.ifmap_valid = valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_ifmap_stream_ctrl.sv
// Self-checking bench for ifmap_stream_ctrl: a one-cycle-latency SRAM model and a
// queue of expected vectors pushed at job start and popped as valid vectors appear.
module tb_ifmap_stream_ctrl;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ifmap_stream_if #(.ADDR_W(8), .DATA_W(64)) bus ();

  ifmap_stream_ctrl #(
    .ADDR_W(8), .DATA_W(64), .ROWS(4), .MAC_LATENCY(9), .RD_LATENCY(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [7:0] a);
    logic [15:0] h;
    h = {8'h00, a};
    return {h, h, h, h};
  endfunction

  // Synchronous SRAM, read latency 1
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem_word(bus.mem_addr);
  end

  // Runs one job starting in cycle T and checks every output in cycles T+1..T+last.
  task automatic run_job(input string name, input logic [7:0] base, input int n,
                         input int abort_at, input int spur1, input int spur2);
    logic [63:0] exp_q[$];
    logic [63:0] exp_d;
    logic [7:0]  exp_a;
    int          done_c, last;
    logic        alive, rd_exp, val_exp, busy_exp, done_exp;
    for (int k = 0; k < n; k++) exp_q.push_back(mem_word(8'(base + 8'(k))));
    done_c = (n == 0) ? 1 : n + 30;
    last   = (abort_at >= 0) ? abort_at + 40 : done_c + 2;
    bus.base_addr = base;
    bus.num_vec   = 9'(n);
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.base_addr = ~base;
    bus.num_vec   = 9'd3;
    for (int c = 1; c <= last; c++) begin
      alive    = (abort_at < 0) || (c <= abort_at);
      rd_exp   = alive && (c <= n);
      val_exp  = alive && (c >= 3) && (c <= n + 2);
      busy_exp = alive && (c <= done_c);
      done_exp = alive && (c == done_c);
      checks++;
      if (bus.mem_rd_en !== rd_exp) begin
        errors++;
        $display("FAIL %s rd_en c=%0d got %b exp %b", name, c, bus.mem_rd_en, rd_exp);
      end
      if (rd_exp) begin
        exp_a = 8'(base + 8'(c - 1));
        checks++;
        if (bus.mem_addr !== exp_a) begin
          errors++;
          $display("FAIL %s addr c=%0d got %h exp %h", name, c, bus.mem_addr, exp_a);
        end
      end
      checks++;
      if (bus.ifmap_valid !== val_exp) begin
        errors++;
        $display("FAIL %s valid c=%0d got %b exp %b", name, c, bus.ifmap_valid, val_exp);
      end
      checks++;
      if (bus.ifmap_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s data c=%0d got %h exp no vector", name, c, bus.ifmap_out);
        end else begin
          exp_d = exp_q.pop_front();
          if (bus.ifmap_out !== exp_d) begin
            errors++;
            $display("FAIL %s data c=%0d got %h exp %h", name, c, bus.ifmap_out, exp_d);
          end
        end
      end else if (bus.ifmap_out !== 64'h0) begin
        errors++;
        $display("FAIL %s zero c=%0d got %h exp 0", name, c, bus.ifmap_out);
      end
      checks++;
      if (bus.busy !== busy_exp) begin
        errors++;
        $display("FAIL %s busy c=%0d got %b exp %b", name, c, bus.busy, busy_exp);
      end
      checks++;
      if (bus.done !== done_exp) begin
        errors++;
        $display("FAIL %s done c=%0d got %b exp %b", name, c, bus.done, done_exp);
      end
      bus.start = (c == spur1) || (c == spur2);
      bus.abort = (c == abort_at);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    if (abort_at < 0) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL %s leftover got %0d vectors exp 0", name, exp_q.size());
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.mem_rd_en, bus.mem_addr, bus.ifmap_out, bus.ifmap_valid, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset outputs got rd=%b a=%h d=%h v=%b b=%b dn=%b exp all 0",
               bus.mem_rd_en, bus.mem_addr, bus.ifmap_out, bus.ifmap_valid, bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    run_job("basic", 8'h10, 4, -1, -1, -1);
    run_job("single", 8'h33, 1, -1, -1, -1);
  endtask

  task automatic test_zero_len();
    run_job("zero_len", 8'h20, 0, -1, -1, -1);
  endtask

  task automatic test_wrap();
    run_job("wrap", 8'hFE, 4, -1, -1, -1);
    run_job("full", 8'h80, 256, -1, -1, -1);
  endtask

  task automatic test_ignored_start();
    run_job("ignored_start", 8'h40, 8, -1, 5, 38);
  endtask

  task automatic test_abort();
    run_job("abort", 8'h50, 8, 3, -1, -1);
    run_job("after_abort", 8'h60, 3, -1, -1, -1);
    bus.base_addr = 8'h70;
    bus.num_vec   = 9'd5;
    bus.start     = 1'b1;
    bus.abort     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL abort_wins c=%0d got busy=%b rd_en=%b exp 0 0", c, bus.busy, bus.mem_rd_en);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_drain();
    bus.base_addr = 8'h20;
    bus.num_vec   = 9'd4;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_drain busy got %b exp 1", bus.busy);
    end
    #2 rst = 1'b1;
    #1 test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset c=%0d got done=%b busy=%b exp 0 0", c, bus.done, bus.busy);
      end
      @(posedge clk); #1;
    end
    run_job("after_reset", 8'h44, 2, -1, -1, -1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.base_addr = '0;
    bus.num_vec   = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_zero_len();
    test_wrap();
    test_ignored_start();
    test_abort();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
